// File: rtl/async_sync_rx_pkg.sv
// Shared types and parameter defaults for the async_sync_rx bundled-data receiver.
package async_sync_rx_pkg;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_DEPTH       = 4;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_SPACE = 2'd1,
    S_ACKED      = 2'd2
  } state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level signal.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/async_sync_rx.sv
// 4-phase bundled-data receiver: synchronizes req_in, acknowledges, and buffers
// words in a small FIFO. Define ASYNC_SYNC_RX_ERR_EN to enable the sticky
// request-withdrawn-before-ack error flag.
module async_sync_rx
  import async_sync_rx_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_in,
  input  logic [WIDTH-1:0]         data_in,
  output logic                     ack_out,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_e               r_state;
  logic                 r_ack;
  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [PW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 w_req_s, w_push, w_pop, w_not_full;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  (req_in),
    .o_q  (w_req_s)
  );

  // Full check uses the pre-pop count, so a pop never makes room in the same cycle.
  assign w_not_full = (r_count != FULL);
  assign w_pop      = (r_count != '0) && out_ready;

  always_comb begin
    w_push = 1'b0;
    if (w_req_s && w_not_full && (r_state == S_IDLE || r_state == S_WAIT_SPACE))
      w_push = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_s) begin
            if (w_not_full) begin
              r_state <= S_ACKED;
              r_ack   <= 1'b1;
            end else begin
              r_state <= S_WAIT_SPACE;
            end
          end
        end
        S_WAIT_SPACE: begin
          if (!w_req_s) begin
            r_state <= S_IDLE;
          end else if (w_not_full) begin
            r_state <= S_ACKED;
            r_ack   <= 1'b1;
          end
        end
        S_ACKED: begin
          if (!w_req_s) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  // Storage is flops, so the head word is a registered output with no read bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= data_in;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef ASYNC_SYNC_RX_ERR_EN
  logic r_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 r_err <= 1'b0;
    else if (r_state == S_WAIT_SPACE && !w_req_s) r_err <= 1'b1;
  end
  assign err_out = r_err;
`else
  assign err_out = 1'b0;
`endif

  assign ack_out   = r_ack;
  assign out_data  = r_mem[r_rd_ptr];
  assign out_valid = (r_count != '0);
  assign count     = r_count;

endmodule

// File: tb/tb_async_sync_rx.sv
// Directed bench for async_sync_rx (default WIDTH=8, DEPTH=4, SYNC_STAGES=2).
module tb_async_sync_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_in;
  logic [7:0] data_in;
  logic       ack_out;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] count;
  logic       err_out;

  int vecs = 0;
  int errs = 0;

  async_sync_rx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_in   (req_in),
    .data_in  (data_in),
    .ack_out  (ack_out),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count    (count),
    .err_out  (err_out)
  );

  always #5 clk = ~clk;

`ifdef ASYNC_SYNC_RX_ERR_EN
  localparam logic [31:0] ERR_EXP = 32'd1;
`else
  localparam logic [31:0] ERR_EXP = 32'd0;
`endif

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Full 4-phase handshake; returns with ack_out low again.
  task automatic hs(input logic [7:0] d);
    int n;
    data_in = d;
    req_in  = 1'b1;
    n = 0;
    while (!ack_out && n < 20) begin step(1); n++; end
    chk("hs_ack_rise", 32'(ack_out), 32'd1);
    req_in = 1'b0;
    n = 0;
    while (ack_out && n < 20) begin step(1); n++; end
    chk("hs_ack_fall", 32'(ack_out), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_in = 1'b0; data_in = 8'h00; out_ready = 1'b0;
    step(2);
    chk("rst_ack",   32'(ack_out),   32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count),     32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_err",   32'(err_out),   32'd0);
    rst_n = 1'b1;
    step(1);

    // Single handshake with downstream ready: 3-cycle ack latency.
    data_in = 8'hA5; req_in = 1'b1; out_ready = 1'b1;
    step(2);
    chk("lat_ack_early", 32'(ack_out), 32'd0);
    step(1);
    chk("lat_ack",   32'(ack_out),   32'd1);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_data",  32'(out_data),  32'hA5);
    chk("lat_count", 32'(count),     32'd1);
    step(1);
    chk("lat_drain", 32'(count), 32'd0);
    req_in = 1'b0;
    step(2);
    chk("fall_ack_early", 32'(ack_out), 32'd1);
    step(1);
    chk("fall_ack", 32'(ack_out), 32'd0);

    // Empty pop attempt has no effect.
    step(2);
    chk("empty_ready_count", 32'(count), 32'd0);
    out_ready = 1'b0;

    // Fill FIFO, fifth request stalls in WAIT_SPACE.
    hs(8'h01); hs(8'h02); hs(8'h03); hs(8'h04);
    chk("full_count", 32'(count),    32'd4);
    chk("full_head",  32'(out_data), 32'h01);
    data_in = 8'h05; req_in = 1'b1;
    step(6);
    chk("wait_ack",   32'(ack_out), 32'd0);
    chk("wait_count", 32'(count),   32'd4);

    // One pop frees a slot; push follows on the next cycle.
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    chk("pop1_count", 32'(count),    32'd3);
    chk("pop1_head",  32'(out_data), 32'h02);
    step(1);
    chk("push5_ack",   32'(ack_out), 32'd1);
    chk("push5_count", 32'(count),   32'd4);
    req_in = 1'b0;
    step(3);
    chk("push5_ack_fall", 32'(ack_out), 32'd0);

    // Full FIFO: pop coincides with first req_s cycle -> push deferred one cycle.
    data_in = 8'h06; req_in = 1'b1;
    step(2);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    chk("coin_ack",   32'(ack_out),  32'd0);
    chk("coin_count", 32'(count),    32'd3);
    chk("coin_head",  32'(out_data), 32'h03);
    step(1);
    chk("coin_push_ack",   32'(ack_out), 32'd1);
    chk("coin_push_count", 32'(count),   32'd4);
    req_in = 1'b0;
    step(3);

    // Drain and check ordering.
    out_ready = 1'b1;
    chk("drain_03", 32'(out_data), 32'h03); step(1);
    chk("drain_04", 32'(out_data), 32'h04); step(1);
    chk("drain_05", 32'(out_data), 32'h05); step(1);
    chk("drain_06", 32'(out_data), 32'h06); step(1);
    chk("drain_count", 32'(count),     32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Full FIFO, request withdrawn before ack.
    hs(8'h07); hs(8'h08); hs(8'h09); hs(8'h0A);
    chk("err_pre", 32'(err_out), 32'd0);
    data_in = 8'h0B; req_in = 1'b1;
    step(4);
    req_in = 1'b0;
    step(4);
    chk("err_flag",  32'(err_out), ERR_EXP);
    chk("err_ack",   32'(ack_out), 32'd0);
    chk("err_count", 32'(count),   32'd4);
    step(3);
    chk("err_hold", 32'(err_out), ERR_EXP);

    // Down to one entry, then enter ACKED with count=2 and reset asynchronously.
    out_ready = 1'b1;
    step(3);
    out_ready = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd1);
    data_in = 8'h0C; req_in = 1'b1;
    step(3);
    chk("pre_rst_ack", 32'(ack_out), 32'd1);
    chk("pre_rst_cnt2", 32'(count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ack",   32'(ack_out),   32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(count),     32'd0);
    chk("arst_data",  32'(out_data),  32'd0);
    chk("arst_err",   32'(err_out),   32'd0);

    // Release with req_in still high: treated as a fresh request.
    step(1);
    rst_n = 1'b1;
    step(2);
    chk("rel_ack_early", 32'(ack_out), 32'd0);
    step(1);
    chk("rel_ack",   32'(ack_out),  32'd1);
    chk("rel_data",  32'(out_data), 32'h0C);
    chk("rel_count", 32'(count),    32'd1);
    req_in = 1'b0;
    step(3);
    chk("rel_ack_fall", 32'(ack_out), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
